// File: rtl/gilbert_elliott_channel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gilbert_pkg
//  Description : Shared types, seeds and LFSR tap table for the channel model
//  Revision    : 1.0 - initial release
// ============================================================================
package gilbert_pkg;

  typedef enum logic {
    GOOD = 1'b0,
    BAD  = 1'b1
  } chan_state_t;

  localparam logic [15:0] C_SEED_S = 16'hACE1;
  localparam logic [15:0] C_SEED_E = 16'h1D2B;

  // Fibonacci feedback masks, bit i set when x^(i+1) is a tap.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      24:      taps = 32'h00E1_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_B400;
    endcase
    return taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gilbert_elliott_channel_lfsr_prng.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prng
//  Description : Maximal-length Fibonacci LFSR, steps only when adv is high
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prng
  import gilbert_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] C_TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (adv) begin
      value_d = {value_q[WIDTH-2:0], ^(value_q & C_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/gilbert_elliott_channel.sv
`default_nettype none
// ============================================================================
//  Module      : gilbert_elliott_channel
//  Description : Two-state burst-error channel on a valid/ready symbol stream
//  Revision    : 1.0 - initial release
// ============================================================================
module gilbert_elliott_channel
  import gilbert_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED_S = LFSR_W'(C_SEED_S),
  parameter logic [LFSR_W-1:0] SEED_E = LFSR_W'(C_SEED_E),
  parameter int                CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [LFSR_W-1:0] cfg_p_gb,
  input  logic [LFSR_W-1:0] cfg_p_bg,
  input  logic [LFSR_W-1:0] cfg_ber_good,
  input  logic [LFSR_W-1:0] cfg_ber_bad,
  input  logic              clear_stats,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              out_ready,
  output logic              channel_state,
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bad_count
);

  localparam int              IDX_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chan_state_t       state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  sym_count_q, sym_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  bad_count_q, bad_count_d;

  logic              accept;
  logic              adv;
  logic              err;
  logic [LFSR_W-1:0] rs;
  logic [LFSR_W-1:0] re;
  logic [LFSR_W-1:0] ber_cur;
  logic [DATA_W-1:0] flip_mask;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign adv      = accept && cfg_enable;

  lfsr_prng #(.WIDTH(LFSR_W), .SEED(SEED_S)) u_state_prng (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .value (rs)
  );

  lfsr_prng #(.WIDTH(LFSR_W), .SEED(SEED_E)) u_error_prng (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .value (re)
  );

  // Error decision uses the pre-transition state and pre-advance PRNG values.
  always_comb begin
    ber_cur   = (state_q == GOOD) ? cfg_ber_good : cfg_ber_bad;
    err       = cfg_enable && (re <= ber_cur);
    flip_mask = '0;
    flip_mask[rs[IDX_W-1:0]] = err;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (adv) begin
      if (state_q == GOOD) begin
        state_d = (rs <= cfg_p_gb) ? BAD : GOOD;
      end else begin
        state_d = (rs <= cfg_p_bg) ? GOOD : BAD;
      end
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ flip_mask;
      out_err_d   = err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating statistics; clear takes priority over any increment.
  always_comb begin
    sym_count_d = sym_count_q;
    err_count_d = err_count_q;
    bad_count_d = bad_count_q;
    if (clear_stats) begin
      sym_count_d = '0;
      err_count_d = '0;
      bad_count_d = '0;
    end else if (accept) begin
      if (sym_count_q != '1) begin
        sym_count_d = sym_count_q + C_CNT_ONE;
      end
      if (err && (err_count_q != '1)) begin
        err_count_d = err_count_q + C_CNT_ONE;
      end
      if (cfg_enable && (state_q == BAD) && (bad_count_q != '1)) begin
        bad_count_d = bad_count_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= GOOD;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      sym_count_q <= '0;
      err_count_q <= '0;
      bad_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      sym_count_q <= sym_count_d;
      err_count_q <= err_count_d;
      bad_count_q <= bad_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_err       = out_err_q;
  assign channel_state = (state_q == GOOD);
  assign sym_count     = sym_count_q;
  assign err_count     = err_count_q;
  assign bad_count     = bad_count_q;

endmodule
`default_nettype wire
